sseg_scan_capture: RTL

//  Receive-side counterpart of the multiplexed 7-segment display driver.
//  - Samples the scanned anode strobes and the shared segment bus.
//  - Reconstructs the four digit patterns and reports complete frames.
//  - Flags scan faults and a stalled scan.
//  - Sits on the board side of the display pins: loopback self-check of the

---
 rtl/sseg_scan_capture.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_capture.sv
// Receive-side capture of a multiplexed 7-segment scan: rebuilds four digits, reports frames,
// scan faults and a stalled scan. Optional glyph-to-hex decode when SSEG_HEX_DECODE_EN is defined.
module sseg_scan_capture #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [7:0]  dig_0,
  output logic [7:0]  dig_1,
  output logic [7:0]  dig_2,
  output logic [7:0]  dig_3,
  output logic        frame_valid,
  output logic        scan_err,
  output logic        stale
`ifdef SSEG_HEX_DECODE_EN
  ,
  output logic [15:0] hex,
  output logic [3:0]  hex_ok
`endif
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned SC_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {AnBlank, AnActive, AnFault} an_state_e;

  logic [3:0]      an_meta_q, an_sync_q, an_prev_q;
  logic [7:0]      sseg_meta_q, sseg_sync_q, sseg_prev_q;
  logic [SC_W-1:0] settle_q, settle_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]      seen_q, seen_d, seen_new;
  logic [3:0][7:0] dig_q, dig_d;
  logic            frame_q, frame_d, err_q, err_d, stale_q, stale_d;
  an_state_e       an_state;
  logic [1:0]      idx;
  logic            changed, capture, prev_fault;

  always_comb begin
    an_state = AnFault;
    idx      = 2'd0;
    unique case (an_sync_q)
      4'b1110: begin an_state = AnActive; idx = 2'd0; end
      4'b1101: begin an_state = AnActive; idx = 2'd1; end
      4'b1011: begin an_state = AnActive; idx = 2'd2; end
      4'b0111: begin an_state = AnActive; idx = 2'd3; end
      4'b1111: an_state = AnBlank;
      default: an_state = AnFault;
    endcase
  end

  assign prev_fault = ($countones(~an_prev_q) > 1);
  assign changed    = ({an_sync_q, sseg_sync_q} != {an_prev_q, sseg_prev_q});
  // Fires exactly once per steady interval: the cycle the count would reach SETTLE_CYCLES.
  assign capture    = (an_state == AnActive) && !changed &&
                      (settle_q == SC_W'(SETTLE_CYCLES - 1));
  assign seen_new   = seen_q | (4'b0001 << idx);

  always_comb begin
    settle_d = settle_q;
    to_cnt_d = to_cnt_q;
    seen_d   = seen_q;
    dig_d    = dig_q;
    frame_d  = 1'b0;
    stale_d  = stale_q;
    err_d    = (an_state == AnFault) && !prev_fault;

    if (changed || an_state != AnActive) begin
      settle_d = '0;
    end else if (settle_q != SC_W'(SETTLE_CYCLES)) begin
      settle_d = settle_q + 1'b1;
    end

    if (capture) begin
      dig_d[idx] = sseg_sync_q;
      to_cnt_d   = '0;
      stale_d    = 1'b0;
      if (seen_new == 4'hF) begin
        frame_d = 1'b1;
        seen_d  = 4'h0;
      end else begin
        seen_d = seen_new;
      end
    end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES - 1)) begin
      to_cnt_d = to_cnt_q + 1'b1;
      // A stalled scan abandons any partial frame.
      if (to_cnt_d == TO_W'(TIMEOUT_CYCLES - 1)) begin
        stale_d = 1'b1;
        seen_d  = 4'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an_meta_q   <= '1;
      an_sync_q   <= '1;
      an_prev_q   <= '1;
      sseg_meta_q <= '1;
      sseg_sync_q <= '1;
      sseg_prev_q <= '1;
      settle_q    <= '0;
      to_cnt_q    <= '0;
      seen_q      <= '0;
      dig_q       <= '1;
      frame_q     <= 1'b0;
      err_q       <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      an_meta_q   <= an;
      an_sync_q   <= an_meta_q;
      an_prev_q   <= an_sync_q;
      sseg_meta_q <= sseg;
      sseg_sync_q <= sseg_meta_q;
      sseg_prev_q <= sseg_sync_q;
      settle_q    <= settle_d;
      to_cnt_q    <= to_cnt_d;
      seen_q      <= seen_d;
      dig_q       <= dig_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
      stale_q     <= stale_d;
    end
  end

  assign dig_0       = dig_q[0];
  assign dig_1       = dig_q[1];
  assign dig_2       = dig_q[2];
  assign dig_3       = dig_q[3];
  assign frame_valid = frame_q;
  assign scan_err    = err_q;
  assign stale       = stale_q;

`ifdef SSEG_HEX_DECODE_EN
  // Returns {ok, nibble}; dp is not part of the glyph.
  function automatic logic [4:0] glyph_to_hex(logic [6:0] g);
    case (g)
      7'h40: return 5'h10;
      7'h79: return 5'h11;
      7'h24: return 5'h12;
      7'h30: return 5'h13;
      7'h19: return 5'h14;
      7'h12: return 5'h15;
      7'h02: return 5'h16;
      7'h78: return 5'h17;
      7'h00: return 5'h18;
      7'h10: return 5'h19;
      7'h08: return 5'h1A;
      7'h03: return 5'h1B;
      7'h46: return 5'h1C;
      7'h21: return 5'h1D;
      7'h06: return 5'h1E;
      7'h0E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  logic [15:0] hex_q;
  logic [3:0]  hex_ok_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hex_q    <= '0;
      hex_ok_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        {hex_ok_q[i], hex_q[4*i +: 4]} <= glyph_to_hex(dig_q[i][6:0]);
      end
    end
  end

  assign hex    = hex_q;
  assign hex_ok = hex_ok_q;
`endif

endmodule
